demux_router: RTL and testbench

- Sequential 1-to-4 demultiplexer: the inverse of the team's 4:1 data mux.
- Accepts a 4-bit word plus a 2-bit lane select on one valid/ready input stream.
- Steers each word into a per-lane FIFO; each lane drains through its own valid/ready output.
- Sits between a single producer and four independent consumers; keeps per-lane order and counts accepted transfers per lane.

---
 rtl/demux_router.sv | 85 ++++++++
 tb/tb_demux_router.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_router.sv
`default_nettype none
// ============================================================================
// Module      : demux_router
// Description : 1-to-4 valid/ready demultiplexer with a FIFO per lane and
//               per-lane accepted-transfer counters.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_router #(
    parameter int DW    = 4,
    parameter int DEPTH = 2,
    parameter int CNTW  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DW-1:0]       in_data,
    input  logic [1:0]          in_sel,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [4*DW-1:0]     out_data,
    output logic [3:0]          out_valid,
    input  logic [3:0]          out_ready,
    output logic [4*CNTW-1:0]   out_cnt
);

    localparam int           c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0] c_FULL = (c_AW+1)'(DEPTH);

    logic [3:0] w_full;

    // Ready depends only on the addressed lane's occupancy, never on valid.
    assign in_ready = ~w_full[in_sel];

    generate
        for (genvar k = 0; k < 4; k++) begin : g_lane
            logic [DW-1:0]   r_mem [DEPTH];
            logic [c_AW-1:0] r_wptr;
            logic [c_AW-1:0] r_rptr;
            logic [c_AW:0]   r_occ;
            logic [CNTW-1:0] r_cnt;
            logic            w_push;
            logic            w_pop;
            logic            w_nempty;

            assign w_nempty  = (r_occ != '0);
            assign w_full[k] = (r_occ == c_FULL);
            assign w_push    = in_valid && !w_full[k] && (in_sel == 2'(k));
            assign w_pop     = w_nempty && out_ready[k];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_wptr <= '0;
                    r_rptr <= '0;
                    r_occ  <= '0;
                    r_cnt  <= '0;
                end else begin
                    if (w_push) begin
                        r_wptr <= r_wptr + 1'b1;
                        r_cnt  <= r_cnt + 1'b1;
                    end
                    if (w_pop) begin
                        r_rptr <= r_rptr + 1'b1;
                    end
                    case ({w_push, w_pop})
                        2'b10:   r_occ <= r_occ + 1'b1;
                        2'b01:   r_occ <= r_occ - 1'b1;
                        default: r_occ <= r_occ;
                    endcase
                end
            end

            // Storage needs no reset: occupancy alone decides what is visible.
            always_ff @(posedge clk) begin
                if (w_push) begin
                    r_mem[r_wptr] <= in_data;
                end
            end

            assign out_valid[k]            = w_nempty;
            assign out_data[k*DW +: DW]    = w_nempty ? r_mem[r_rptr] : '0;
            assign out_cnt[k*CNTW +: CNTW] = r_cnt;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_demux_router.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_router
// Description : Scoreboard bench for demux_router; directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_router;

    logic        clk;
    logic        rst_n;
    logic [3:0]  in_data;
    logic [1:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] exp_q [4][$];
    logic [7:0] exp_cnt [4];

    demux_router #(.DW(4), .DEPTH(2), .CNTW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_cnt   (out_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt_vec();
        return {exp_cnt[3], exp_cnt[2], exp_cnt[1], exp_cnt[0]};
    endfunction

    // Monitor: every handshake on an output lane must match the queue head.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rst_n && out_valid[k] && out_ready[k]) begin
                if (exp_q[k].size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL lane%0d_unexpected: got %0h, expected no output", k, out_data[k*4 +: 4]);
                end else begin
                    chk($sformatf("lane%0d_data", k), 64'(out_data[k*4 +: 4]), 64'(exp_q[k].pop_front()));
                end
            end
        end
    end

    task automatic clear_model();
        for (int k = 0; k < 4; k++) begin
            exp_q[k].delete();
            exp_cnt[k] = 8'h00;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst_n = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic push(input logic [1:0] sel, input logic [3:0] d);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = d;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q[sel].push_back(d);
                exp_cnt[sel] = exp_cnt[sel] + 8'h01;
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL push_timeout: lane %0d got no ready, expected ready within 20 cycles", sel);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_data   = '0;
        in_sel    = '0;
        in_valid  = 1'b0;
        out_ready = '0;
        clear_model();
        #1;
        chk("ready_in_reset", 64'(in_ready), 64'(1'b1));
        do_reset();

        // 1: idle after reset
        repeat (3) begin
            @(negedge clk);
            chk("idle_valid", 64'(out_valid), 64'h0);
            chk("idle_data",  64'(out_data),  64'h0);
            chk("idle_cnt",   64'(out_cnt),   64'h0);
        end
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s);
            #1;
            chk($sformatf("idle_ready_sel%0d", s), 64'(in_ready), 64'(1'b1));
        end

        // 2: single word to lane2
        @(posedge clk); #1;
        push(2'd2, 4'hA);
        @(negedge clk);
        chk("l2_valid", 64'(out_valid), 64'h4);
        chk("l2_data",  64'(out_data),  64'h0A00);
        chk("l2_cnt",   64'(out_cnt),   64'(exp_cnt_vec()));
        chk("l2_cnt_is1", 64'(out_cnt[23:16]), 64'h1);
        @(posedge clk); #1;
        out_ready = 4'b0100;
        @(posedge clk); #1;
        out_ready = 4'b0000;
        @(negedge clk);
        chk("l2_drained_valid", 64'(out_valid), 64'h0);
        chk("l2_drained_data",  64'(out_data),  64'h0);

        // 3: back-pressure on lane1
        @(posedge clk); #1;
        push(2'd1, 4'h3);
        push(2'd1, 4'h5);
        in_sel = 2'd1;
        #1;
        chk("l1_full_ready", 64'(in_ready), 64'h0);
        in_sel = 2'd0;
        #1;
        chk("l0_ready_while_l1_full", 64'(in_ready), 64'h1);
        in_valid = 1'b1;
        in_sel   = 2'd1;
        in_data  = 4'h7;
        repeat (2) begin
            @(negedge clk);
            chk("l1_stall_ready", 64'(in_ready), 64'h0);
            chk("l1_stall_cnt",   64'(out_cnt[15:8]), 64'h2);
        end
        @(posedge clk); #1;
        out_ready = 4'b0010;
        push(2'd1, 4'h7);
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        chk("l1_cnt3",   64'(out_cnt[15:8]), 64'h3);
        chk("l1_empty",  64'(out_valid[1]),  64'h0);
        out_ready = 4'b0000;

        // 4: simultaneous push/pop on lane0
        @(posedge clk); #1;
        push(2'd0, 4'h1);
        out_ready = 4'b0001;
        push(2'd0, 4'h2);
        out_ready = 4'b0000;
        @(negedge clk);
        chk("l0_pp_valid", 64'(out_valid[0]),  64'h1);
        chk("l0_pp_head",  64'(out_data[3:0]), 64'h2);
        @(posedge clk); #1;
        push(2'd0, 4'h3);
        in_valid  = 1'b1;
        in_sel    = 2'd0;
        in_data   = 4'h4;
        out_ready = 4'b0001;
        @(negedge clk);
        chk("l0_full_refuse_ready", 64'(in_ready), 64'h0);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 4'b0000;
        @(negedge clk);
        chk("l0_after_pop_head", 64'(out_data[3:0]), 64'h3);
        chk("l0_after_pop_cnt",  64'(out_cnt[7:0]),  64'h3);
        @(posedge clk); #1;
        out_ready = 4'b0001;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("l0_only_one_left", 64'(out_valid[0]), 64'h0);
        out_ready = 4'b0000;

        // 5: counter wrap on lane3
        do_reset();
        out_ready = 4'b1000;
        for (int i = 0; i < 255; i++) push(2'd3, 4'(i));
        @(negedge clk);
        chk("l3_cnt_ff",    64'(out_cnt[31:24]), 64'hFF);
        chk("l3_model_ff",  64'(out_cnt),        64'(exp_cnt_vec()));
        @(posedge clk); #1;
        push(2'd3, 4'hF);
        @(negedge clk);
        chk("l3_cnt_wrap",  64'(out_cnt[31:24]), 64'h00);
        chk("l0_2_cnt_zero", 64'(out_cnt[23:0]), 64'h0);
        repeat (3) @(posedge clk);
        #1;
        out_ready = 4'b0000;

        // 6: reset mid-operation with all lanes full
        for (int k = 0; k < 4; k++) begin
            push(2'(k), 4'(k + 1));
            push(2'(k), 4'(k + 8));
        end
        @(negedge clk);
        chk("all_full_valid", 64'(out_valid), 64'hF);
        chk("all_full_data",  64'(out_data),  64'h4321);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'h0);
        chk("async_rst_data",  64'(out_data),  64'h0);
        chk("async_rst_cnt",   64'(out_cnt),   64'h0);
        chk("async_rst_ready", 64'(in_ready),  64'h1);
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 4'b1111;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_no_output", 64'(out_valid), 64'h0);
        end
        @(posedge clk); #1;
        push(2'd0, 4'h9);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("post_rst_cnt", 64'(out_cnt), 64'(exp_cnt_vec()));

        for (int k = 0; k < 4; k++) begin
            chk($sformatf("lane%0d_drained", k), 64'(exp_q[k].size()), 64'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
